lfsr_core: RTL and testbench

// Parallel (multi-bit-per-cycle) LFSR engine for CRC, scrambler and PRBS use.

---
 rtl/lfsr_core.sv | 123 ++++++++++++
 tb/tb_lfsr_core.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_core.sv
// Parallel LFSR engine (CRC / scrambler / PRBS): DATA_WIDTH bit-steps per cycle as a GF(2) linear map,
// with optional registered copies of the combinational results.
`timescale 1ns/1ps
module lfsr_core #(
    parameter int                      LFSR_WIDTH        = 32,
    parameter logic [LFSR_WIDTH-1:0]   LFSR_POLY         = 32'h04C11DB7,
    parameter string                   LFSR_CONFIG       = "GALOIS",
    parameter int                      LFSR_FEED_FORWARD = 0,
    parameter int                      REVERSE           = 0,
    parameter int                      DATA_WIDTH        = 8,
    parameter string                   STYLE             = "AUTO",
    parameter logic [LFSR_WIDTH-1:0]   RESET_STATE       = {LFSR_WIDTH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [LFSR_WIDTH-1:0]   state_in,
    input  logic                    en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [LFSR_WIDTH-1:0]   state_out,
    output logic [DATA_WIDTH-1:0]   data_q,
    output logic [LFSR_WIDTH-1:0]   state_q
);
    localparam int W  = LFSR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int NI = W + DW;
    localparam bit IS_FIB   = (LFSR_CONFIG == "FIBONACCI");
    localparam bit FF       = (LFSR_FEED_FORWARD != 0);
    localparam bit USE_LOOP = (STYLE == "LOOP");

    typedef logic [NI-1:0] vec_t;

    if (LFSR_CONFIG != "GALOIS" && LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
        $error("lfsr_core: LFSR_CONFIG must be GALOIS or FIBONACCI");
    end
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
        $error("lfsr_core: STYLE must be AUTO, LOOP or REDUCTION");
    end
    if (W < 2 || W > 64 || DW < 1 || DW > 256) begin : g_bad_width
        $error("lfsr_core: LFSR_WIDTH must be 2..64 and DATA_WIDTH 1..256");
    end

    // Symbolic bit-serial run: each state/output bit is tracked as the set of inputs
    // ({data_in, state_in}) it XORs together. Reflected mode runs in the mirrored index space.
    function automatic vec_t dep_mask(input int out_idx);
        logic [W-1:0][NI-1:0]  s;
        logic [W-1:0][NI-1:0]  s_nx;
        logic [DW-1:0][NI-1:0] o;
        vec_t d;
        vec_t fb;
        int   di;
        for (int i = 0; i < W; i++) begin
            s[i] = '0;
            s[i][(REVERSE != 0) ? (W - 1 - i) : i] = 1'b1;
        end
        o    = '0;
        s_nx = '0;
        for (int t = 0; t < DW; t++) begin
            di = (REVERSE != 0) ? t : (DW - 1 - t);
            d  = '0;
            d[W + di] = 1'b1;
            fb = s[W-1];
            if (IS_FIB) begin
                for (int i = 0; i < W - 1; i++) begin
                    if (LFSR_POLY[i+1]) fb = fb ^ s[i];
                end
                s_nx[0] = FF ? d : (fb ^ d);
                o[di]   = FF ? (fb ^ d) : s_nx[0];
                for (int i = 1; i < W; i++) s_nx[i] = s[i-1];
            end else begin
                if (!FF) fb = fb ^ d;
                o[di] = FF ? (fb ^ d) : fb;
                for (int i = 0; i < W; i++) begin
                    if (i == 0) s_nx[i] = '0;
                    else        s_nx[i] = s[i-1];
                    if (LFSR_POLY[i]) s_nx[i] = s_nx[i] ^ fb;
                end
                if (FF) s_nx[0] = s_nx[0] ^ d;
            end
            s = s_nx;
        end
        if (out_idx < W) return s[(REVERSE != 0) ? (W - 1 - out_idx) : out_idx];
        return o[out_idx - W];
    endfunction

    function automatic logic parity_loop(input vec_t v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < NI; i++) p = p ^ v[i];
        return p;
    endfunction

    vec_t in_vec;
    assign in_vec = {data_in, state_in};

    for (genvar gi = 0; gi < W; gi++) begin : g_state
        localparam vec_t MASK = dep_mask(gi);
        if (USE_LOOP) begin : g_loop
            assign state_out[gi] = parity_loop(in_vec & MASK);
        end else begin : g_red
            assign state_out[gi] = ^(in_vec & MASK);
        end
    end

    for (genvar gi = 0; gi < DW; gi++) begin : g_data
        localparam vec_t MASK = dep_mask(W + gi);
        if (USE_LOOP) begin : g_loop
            assign data_out[gi] = parity_loop(in_vec & MASK);
        end else begin : g_red
            assign data_out[gi] = ^(in_vec & MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            data_q  <= '0;
        end else if (en) begin
            state_q <= state_out;
            data_q  <= data_out;
        end
    end
endmodule

// File: tb/tb_lfsr_core.sv
// Directed bench for lfsr_core: CRC-32, eight GF(2) configurations against a bit-serial model,
// PRBS7 period, scrambler/descrambler round trip and the registered path.
`timescale 1ns/1ps
module tb_lfsr_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // CRC-32 (Ethernet) instance
    logic [7:0]  crc_data_in;
    logic [31:0] crc_state_in;
    logic [7:0]  crc_data_out, crc_data_q;
    logic [31:0] crc_state_out, crc_state_q;

    lfsr_core #(
        .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
        .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8)
    ) u_crc (
        .clk(clk), .rst(rst), .data_in(crc_data_in), .state_in(crc_state_in), .en(en),
        .data_out(crc_data_out), .state_out(crc_state_out), .data_q(crc_data_q), .state_q(crc_state_q)
    );

    // Eight configurations: bit0 = feed-forward, bit1 = reverse, bit2 = Fibonacci
    logic [7:0]  cfg_data_in;
    logic [15:0] cfg_state_in;
    logic [7:0]  cd_out [8];
    logic [7:0]  cd_q   [8];
    logic [15:0] cs_out [8];
    logic [15:0] cs_q   [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_cfg
        if (gi >= 4) begin : g_fib
            lfsr_core #(
                .LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("FIBONACCI"),
                .LFSR_FEED_FORWARD(gi % 2), .REVERSE((gi / 2) % 2), .DATA_WIDTH(8)
            ) u_dut (
                .clk(clk), .rst(rst), .data_in(cfg_data_in), .state_in(cfg_state_in), .en(en),
                .data_out(cd_out[gi]), .state_out(cs_out[gi]), .data_q(cd_q[gi]), .state_q(cs_q[gi])
            );
        end else begin : g_gal
            lfsr_core #(
                .LFSR_WIDTH(16), .LFSR_POLY(16'h1021), .LFSR_CONFIG("GALOIS"),
                .LFSR_FEED_FORWARD(gi % 2), .REVERSE((gi / 2) % 2), .DATA_WIDTH(8)
            ) u_dut (
                .clk(clk), .rst(rst), .data_in(cfg_data_in), .state_in(cfg_state_in), .en(en),
                .data_out(cd_out[gi]), .state_out(cs_out[gi]), .data_q(cd_q[gi]), .state_q(cs_q[gi])
            );
        end
    end

    // PRBS7 x^7+x^6+1, one bit per step
    logic [6:0] p_state_in, p_state_out, p_state_q;
    logic [0:0] p_data_in, p_data_out, p_data_q;

    lfsr_core #(
        .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
        .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1), .RESET_STATE(7'h7F)
    ) u_prbs (
        .clk(clk), .rst(rst), .data_in(p_data_in), .state_in(p_state_in), .en(en),
        .data_out(p_data_out), .state_out(p_state_out), .data_q(p_data_q), .state_q(p_state_q)
    );

    // Scrambler / descrambler pair
    logic [7:0] scr_data_in, scr_data_out, scr_data_q, dsc_data_in, dsc_data_out, dsc_data_q;
    logic [6:0] scr_state_in, scr_state_out, scr_state_q, dsc_state_in, dsc_state_out, dsc_state_q;

    lfsr_core #(
        .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
        .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8), .STYLE("LOOP")
    ) u_scr (
        .clk(clk), .rst(rst), .data_in(scr_data_in), .state_in(scr_state_in), .en(en),
        .data_out(scr_data_out), .state_out(scr_state_out), .data_q(scr_data_q), .state_q(scr_state_q)
    );

    lfsr_core #(
        .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
        .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(8), .STYLE("REDUCTION")
    ) u_dsc (
        .clk(clk), .rst(rst), .data_in(dsc_data_in), .state_in(dsc_state_in), .en(en),
        .data_out(dsc_data_out), .state_out(dsc_state_out), .data_q(dsc_data_q), .state_q(dsc_state_q)
    );

    // Bit-serial reference operating directly on the (possibly reflected) register, 8 data bits.
    // Returns {data_out[7:0], state[63:0]}.
    function automatic logic [71:0] model(input int w, input bit fib, input bit ff, input bit rev,
                                          input logic [63:0] poly, input logic [63:0] st,
                                          input logic [7:0] dat);
        logic [63:0] s, rp, mk;
        logic [7:0]  dout;
        logic        top, fb, d, n;
        int          idx;
        mk = (64'd1 << w) - 64'd1;
        rp = '0;
        for (int j = 0; j < w; j++) rp[j] = poly[w-1-j];
        s    = st & mk;
        dout = '0;
        for (int k = 0; k < 8; k++) begin
            idx = rev ? k : 7 - k;
            d   = dat[idx];
            top = rev ? s[0] : s[w-1];
            if (!fib) begin
                fb = ff ? top : (top ^ d);
                if (rev) begin
                    s = (s >> 1) ^ (fb ? rp : 64'd0);
                    if (ff) s = s ^ (64'(d) << (w - 1));
                end else begin
                    s = ((s << 1) ^ (fb ? poly : 64'd0)) & mk;
                    if (ff) s = s ^ 64'(d);
                end
                dout[idx] = ff ? (d ^ fb) : fb;
            end else begin
                if (rev) fb = s[0] ^ (^((s >> 1) & rp));
                else     fb = s[w-1] ^ (^(((s << 1) & mk) & poly));
                n = ff ? d : (fb ^ d);
                dout[idx] = ff ? (d ^ fb) : n;
                if (rev) s = (s >> 1) | (64'(n) << (w - 1));
                else     s = ((s << 1) & mk) | 64'(n);
            end
        end
        return {dout, s};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (crc_state_q !== 32'hFFFFFFFF) $display("FAIL reset_state_q: got %h expected %h", crc_state_q, 32'hFFFFFFFF);
        else pass_cnt++;
        total_cnt++;
        if (crc_data_q !== 8'h00) $display("FAIL reset_data_q: got %h expected %h", crc_data_q, 8'h00);
        else pass_cnt++;
        total_cnt++;
        if (p_state_q !== 7'h7F) $display("FAIL reset_prbs_state_q: got %h expected %h", p_state_q, 7'h7F);
        else pass_cnt++;
        rst = 1'b0;
        $display("reset: crc state_q=%h data_q=%h prbs state_q=%h", crc_state_q, crc_data_q, p_state_q);
    endtask

    task automatic test_crc_byte();
        logic [71:0] exp;
        crc_state_in = 32'hFFFFFFFF;
        crc_data_in  = 8'h00;
        #1;
        exp = model(32, 1'b0, 1'b0, 1'b1, 64'h04C11DB7, 64'hFFFFFFFF, 8'h00);
        total_cnt++;
        if (crc_state_out !== 32'h2DFD1072) $display("FAIL crc_byte_state: got %h expected %h", crc_state_out, 32'h2DFD1072);
        else pass_cnt++;
        total_cnt++;
        if (crc_data_out !== exp[71:64]) $display("FAIL crc_byte_data: got %h expected %h", crc_data_out, exp[71:64]);
        else pass_cnt++;
        $display("crc byte: state_in=ffffffff data_in=00 -> state_out=%h data_out=%h", crc_state_out, crc_data_out);
    endtask

    task automatic test_linearity();
        crc_state_in = '0;
        crc_data_in  = '0;
        cfg_state_in = '0;
        cfg_data_in  = '0;
        #1;
        total_cnt++;
        if ({crc_state_out, crc_data_out} !== 40'd0) $display("FAIL linear_crc: got %h/%h expected 0/0", crc_state_out, crc_data_out);
        else pass_cnt++;
        for (int c = 0; c < 8; c++) begin
            total_cnt++;
            if ({cs_out[c], cd_out[c]} !== 24'd0) $display("FAIL linear_cfg%0d: got %h/%h expected 0/0", c, cs_out[c], cd_out[c]);
            else pass_cnt++;
        end
        $display("linearity: zero state and data checked on 9 instances");
    endtask

    task automatic test_configs();
        logic [15:0] vst [4];
        logic [7:0]  vdt [4];
        logic [71:0] exp;
        vst = '{16'hFFFF, 16'h1234, 16'h0001, 16'h8000};
        vdt = '{8'h00,    8'hA5,    8'h80,    8'h3C};
        for (int v = 0; v < 4; v++) begin
            cfg_state_in = vst[v];
            cfg_data_in  = vdt[v];
            #1;
            if (v == 0) begin
                total_cnt++;
                if (cs_out[0] !== 16'hE1F0) $display("FAIL ccitt_ffff_00: got %h expected %h", cs_out[0], 16'hE1F0);
                else pass_cnt++;
            end
            for (int c = 0; c < 8; c++) begin
                exp = model(16, c >= 4, (c % 2) == 1, ((c / 2) % 2) == 1, 64'h1021, 64'(vst[v]), vdt[v]);
                total_cnt++;
                if (cs_out[c] !== exp[15:0]) $display("FAIL cfg%0d_state v%0d: got %h expected %h", c, v, cs_out[c], exp[15:0]);
                else pass_cnt++;
                total_cnt++;
                if (cd_out[c] !== exp[71:64]) $display("FAIL cfg%0d_data v%0d: got %h expected %h", c, v, cd_out[c], exp[71:64]);
                else pass_cnt++;
            end
            $display("configs: vector %0d state_in=%h data_in=%h checked on 8 configs", v, vst[v], vdt[v]);
        end
    endtask

    task automatic test_prbs_period();
        logic [6:0] cur;
        int         count;
        p_data_in = 1'b0;
        cur       = 7'h7F;
        count     = 0;
        do begin
            p_state_in = cur;
            #1;
            cur = p_state_out;
            count++;
        end while (cur != 7'h7F && count < 200);
        total_cnt++;
        if (count !== 127) $display("FAIL prbs7_period: got %0d expected %0d", count, 127);
        else pass_cnt++;
        $display("prbs7: period %0d", count);
    endtask

    task automatic test_scramble_roundtrip();
        logic [7:0] msg [6];
        logic [6:0] s1, s2;
        msg = '{8'h00, 8'hFF, 8'h5A, 8'h01, 8'h80, 8'hC3};
        s1 = 7'h2B;
        s2 = 7'h2B;
        for (int i = 0; i < 6; i++) begin
            scr_state_in = s1;
            scr_data_in  = msg[i];
            #1;
            dsc_state_in = s2;
            dsc_data_in  = scr_data_out;
            #1;
            total_cnt++;
            if (dsc_data_out !== msg[i]) $display("FAIL descramble_%0d: got %h expected %h", i, dsc_data_out, msg[i]);
            else pass_cnt++;
            $display("scramble: plain=%h scrambled=%h recovered=%h", msg[i], scr_data_out, dsc_data_out);
            s1 = scr_state_out;
            s2 = dsc_state_out;
        end
    endtask

    task automatic test_crc_check_string();
        logic [7:0] msg [9];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 9; i++) begin
            crc_state_in = crc_state_q;
            crc_data_in  = msg[i];
            en = 1'b1;
            @(posedge clk);
            #1;
            $display("crc chain: byte %h -> state_q=%h", msg[i], crc_state_q);
        end
        en = 1'b0;
        total_cnt++;
        if (crc_state_q !== 32'h340BC6D9) $display("FAIL crc_123456789: got %h expected %h", crc_state_q, 32'h340BC6D9);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [71:0] exp;
        // en=0 holds the captured value
        crc_state_in = 32'h12345678;
        crc_data_in  = 8'h9A;
        en = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (crc_state_q !== 32'h340BC6D9) $display("FAIL hold_state_q: got %h expected %h", crc_state_q, 32'h340BC6D9);
        else pass_cnt++;
        // en=1 captures the combinational result one cycle later
        crc_state_in = 32'hFFFFFFFF;
        crc_data_in  = 8'h00;
        en = 1'b1;
        @(posedge clk);
        #1;
        exp = model(32, 1'b0, 1'b0, 1'b1, 64'h04C11DB7, 64'hFFFFFFFF, 8'h00);
        total_cnt++;
        if (crc_state_q !== 32'h2DFD1072) $display("FAIL capture_state_q: got %h expected %h", crc_state_q, 32'h2DFD1072);
        else pass_cnt++;
        total_cnt++;
        if (crc_data_q !== exp[71:64]) $display("FAIL capture_data_q: got %h expected %h", crc_data_q, exp[71:64]);
        else pass_cnt++;
        $display("capture: state_q=%h data_q=%h", crc_state_q, crc_data_q);
        // rst wins over en
        crc_state_in = 32'h0F0F0F0F;
        crc_data_in  = 8'h55;
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (crc_state_q !== 32'hFFFFFFFF) $display("FAIL midrun_rst_state_q: got %h expected %h", crc_state_q, 32'hFFFFFFFF);
        else pass_cnt++;
        total_cnt++;
        if (crc_data_q !== 8'h00) $display("FAIL midrun_rst_data_q: got %h expected %h", crc_data_q, 8'h00);
        else pass_cnt++;
        $display("mid-run reset: state_q=%h data_q=%h", crc_state_q, crc_data_q);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        crc_data_in  = '0;
        crc_state_in = '0;
        cfg_data_in  = '0;
        cfg_state_in = '0;
        p_data_in    = '0;
        p_state_in   = '0;
        scr_data_in  = '0;
        scr_state_in = '0;
        dsc_data_in  = '0;
        dsc_state_in = '0;
        test_reset();
        test_crc_byte();
        test_linearity();
        test_configs();
        test_prbs_period();
        test_scramble_roundtrip();
        test_crc_check_string();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
